// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common_pkg
// Shared definitions for the bus fabric.
//   DATA_WIDTH          : width of one bus beat in bits
//   ARB_NUM_REQ_DEFAULT : default number of requesters on the bus arbiter
//   arb_idx_t           : requester index type for the default arbiter size
//   state_t             : two-state controller state (Idle / Busy)
// ---------------------------------------------------------------------------
package common_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int ARB_NUM_REQ_DEFAULT = 4;

  typedef logic [$clog2(ARB_NUM_REQ_DEFAULT)-1:0] arb_idx_t;

  typedef enum logic {
    Idle = 1'b0,
    Busy = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin priority search. Starting just above the
// pointer and wrapping around, returns the first requester whose bit is set.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    index of the most recent winner
//   idx   out IDX_W    selected requester (ptr when nothing is found)
//   found out 1        at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Two ascending passes avoid modulo arithmetic for non power-of-two sizes:
  // the first pass finds the lowest requester strictly above the pointer,
  // the second (wrap-around) pass the lowest requester overall.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j > int'(ptr))) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
// Round-robin arbiter that shares one bus data path between NUM_REQ burst
// requesters. A whole burst is granted; ownership lasts until the beat
// flagged last is accepted by the bus. At least one Idle cycle separates
// bursts.
//
// Optional feature (macro BUS_ARB_TIMEOUT_EN): a stall counter force-releases
// an owner that has not transferred a beat for TIMEOUT_CYCLES consecutive
// Busy cycles, pulsing timeout_o. With the macro undefined timeout_o is tied
// low and a stalled owner holds the bus indefinitely. When ENABLE_LOGGING is
// also defined, a forced release is reported as a LOG message.
//
// Ports:
//   clk          in  1                   clock, rising edge
//   rst_n        in  1                   asynchronous active-low reset
//   req_i        in  NUM_REQ             request / beat valid of the owner
//   req_data_i   in  NUM_REQ*DATA_WIDTH  flattened beat data, slice k = req k
//   req_last_i   in  NUM_REQ             last beat of burst
//   gnt_o        out NUM_REQ             one-hot owner, registered
//   req_ready_o  out NUM_REQ             bus_ready_i gated by gnt_o
//   bus_valid_o  out 1                   bus beat valid
//   bus_data_o   out DATA_WIDTH          bus beat data
//   bus_last_o   out 1                   bus last
//   bus_ready_i  in  1                   bus accepts beat
//   busy_o       out 1                   arbiter in Busy
//   owner_o      out IDX_W               current or most recent owner
//   timeout_o    out 1                   one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module bus_rr_arbiter
  import common_pkg::*;
#(
  parameter  int NUM_REQ        = ARB_NUM_REQ_DEFAULT,
  parameter  int DATA_WIDTH     = common_pkg::DATA_WIDTH,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]              req_last_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            bus_valid_o,
  output logic [DATA_WIDTH-1:0]           bus_data_o,
  output logic                            bus_last_o,
  input  logic                            bus_ready_i,
  output logic                            busy_o,
  output logic [IDX_W-1:0]                owner_o,
  output logic                            timeout_o
);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("bus_rr_arbiter: NUM_REQ must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_rr_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 xfer;
  logic                 stall_expired;

  // The round-robin pointer is always equal to the owner register (both reset
  // to NUM_REQ-1 and both load the winner), so one register serves both.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_i),
    .ptr   (owner_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Combinational pass-through from the owner while Busy; the bus sees zeros
  // otherwise. last is qualified by the owner's request so a bubble never
  // presents a stray last flag.
  always_comb begin
    bus_valid_o = 1'b0;
    bus_last_o  = 1'b0;
    bus_data_o  = '0;
    if (state_q == Busy) begin
      bus_valid_o = req_i[owner_q];
      bus_data_o  = req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      bus_last_o  = req_last_i[owner_q] & req_i[owner_q];
    end
  end

  assign xfer        = bus_valid_o & bus_ready_i;
  assign req_ready_o = gnt_q & {NUM_REQ{bus_ready_i}};
  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q == Busy);
  assign owner_o     = owner_q;

  // Next-state logic. A grant is issued only from Idle, so release and
  // re-grant can never happen on the same edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    unique case (state_q)
      Idle: begin
        if (pick_found) begin
          state_d         = Busy;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
        end
      end
      Busy: begin
        if (xfer && bus_last_o) begin
          state_d = Idle;
          gnt_d   = '0;
        end else if (stall_expired) begin
          state_d = Idle;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = Idle;
        gnt_d   = '0;
      end
    endcase
  end

  // State, grant and owner registers. Reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle;
      gnt_q   <= '0;
      owner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_q;

  // The counter holds the number of stalled Busy cycles already completed;
  // the release fires on the edge that ends the TIMEOUT_CYCLES-th one.
  assign stall_expired = (state_q == Busy) && !xfer &&
                         (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= stall_expired;
      if ((state_q == Busy) && !xfer && !stall_expired) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end else begin
        stall_cnt_q <= '0;
      end
    end
  end

  assign timeout_o = timeout_q;

`ifdef ENABLE_LOGGING
  always_ff @(posedge clk) begin
    if (stall_expired) begin
      $display("LOG bus_rr_arbiter: forced release of owner %0d", owner_q);
    end
  end
`endif

`else
  assign stall_expired = 1'b0;
  assign timeout_o     = 1'b0;
`endif

endmodule
